// File: rtl/cc_switch_seq.sv
`default_nettype none
// ============================================================================
//  Module      : cc_switch_seq
//  Description : Break-before-make relay commutation sequencer. A synchronised
//                request edge starts a timed BREAK / GAP / MAKE / DONE
//                sequence that switches the connected channel. Requests that
//                arrive while busy are dropped and counted (saturating).
//  Revision    : 1.0 - initial release
// ============================================================================
module cc_switch_seq #(
    parameter int unsigned T_BREAK = 800000,  // clocks relay_off is held high
    parameter int unsigned T_GAP   = 400000,  // clocks with both drives low
    parameter int unsigned T_MAKE  = 800000   // clocks relay_on is held high
    // Each of T_BREAK, T_GAP and T_MAKE must lie in 1 .. 2^24-1.
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    input  logic [5:0] chan,
    output logic       relay_off,
    output logic       relay_on,
    output logic [5:0] chan_out,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [3:0] ovr_cnt
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_break = 3'd1;
    localparam logic [2:0] c_st_gap   = 3'd2;
    localparam logic [2:0] c_st_make  = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    // Timers count down from T-1 to 0, so a phase lasts exactly T clocks.
    localparam logic [23:0] c_break_ld = 24'(T_BREAK - 1);
    localparam logic [23:0] c_gap_ld   = 24'(T_GAP - 1);
    localparam logic [23:0] c_make_ld  = 24'(T_MAKE - 1);
    localparam logic [5:0]  c_num_chan = 6'd60;

    logic [2:0]  r_sync;
    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic [23:0] r_timer;
    logic [5:0]  r_chan_lat;
    logic        w_edge;
    logic        w_tmr_zero;
    logic        w_accept;
    logic        w_reject;
    logic        w_overrun;
    logic        w_relay_off;
    logic        w_relay_on;
    logic        w_busy;
    logic        w_done;

    // Stage 0 absorbs metastability; the edge is taken between stages 1 and 2
    // so a long request pulse yields exactly one edge.
    assign w_edge     = r_sync[1] & ~r_sync[2];
    assign w_tmr_zero = (r_timer == 24'd0);
    assign w_accept   = w_edge && (r_state == c_st_idle) && (chan <  c_num_chan);
    assign w_reject   = w_edge && (r_state == c_st_idle) && (chan >= c_num_chan);
    // Includes the DONE cycle: an edge there is an overrun, never a new start.
    assign w_overrun  = w_edge && (r_state != c_st_idle);

    // Request synchroniser / edge-detect shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_sync <= 3'b000;
        else     r_sync <= {r_sync[1:0], req};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_next;
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle:  if (w_accept)   w_next = c_st_break;
            c_st_break: if (w_tmr_zero) w_next = c_st_gap;
            c_st_gap:   if (w_tmr_zero) w_next = c_st_make;
            c_st_make:  if (w_tmr_zero) w_next = c_st_done;
            c_st_done:                  w_next = c_st_idle;
            default:                    w_next = c_st_idle;
        endcase
    end

    // Output decode from the next state so the registered drives align with
    // the state they belong to.
    always_comb begin
        w_relay_off = (w_next == c_st_break);
        w_relay_on  = (w_next == c_st_make);
        w_busy      = (w_next != c_st_idle);
        w_done      = (w_next == c_st_done);
    end

    // Phase timer: loaded on each phase entry, counts down to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= 24'd0;
        end else begin
            case (r_state)
                c_st_idle:  if (w_accept) r_timer <= c_break_ld;
                c_st_break: r_timer <= w_tmr_zero ? c_gap_ld  : r_timer - 24'd1;
                c_st_gap:   r_timer <= w_tmr_zero ? c_make_ld : r_timer - 24'd1;
                c_st_make:  r_timer <= w_tmr_zero ? 24'd0     : r_timer - 24'd1;
                default:    r_timer <= 24'd0;
            endcase
        end
    end

    // Target channel latch, captured only when a request is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_chan_lat <= 6'd0;
        else if (w_accept) r_chan_lat <= chan;
    end

    // Registered outputs; chan_out follows the latch on MAKE entry only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            relay_off <= 1'b0;
            relay_on  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            chan_out  <= 6'd0;
        end else begin
            relay_off <= w_relay_off;
            relay_on  <= w_relay_on;
            busy      <= w_busy;
            done      <= w_done;
            err       <= w_reject;
            if ((r_state == c_st_gap) && (w_next == c_st_make))
                chan_out <= r_chan_lat;
        end
    end

    // Saturating count of requests dropped while a sequence is running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              ovr_cnt <= 4'd0;
        else if (w_overrun && ovr_cnt != 4'hF) ovr_cnt <= ovr_cnt + 4'd1;
    end

endmodule
`default_nettype wire

// File: tb/tb_cc_switch_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cc_switch_seq
//  Description : Directed self-checking bench for cc_switch_seq with short
//                phase timers (BREAK=4, GAP=2, MAKE=3).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cc_switch_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       req;
    logic [5:0] chan;
    logic       relay_off;
    logic       relay_on;
    logic [5:0] chan_out;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] ovr_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    cc_switch_seq #(
        .T_BREAK (4),
        .T_GAP   (2),
        .T_MAKE  (3)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .chan      (chan),
        .relay_off (relay_off),
        .relay_on  (relay_on),
        .chan_out  (chan_out),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .ovr_cnt   (ovr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One accepted sequence; req driven in cycle 0 so BREAK is cycles 3-6,
    // GAP 7-8, MAKE 9-11, DONE 12. An optional extra 1-cycle pulse at 'extra'.
    task automatic run_accepted(input logic [5:0] ch, input logic [5:0] prev,
                                input int len, input int extra);
        for (int c = 0; c < 15; c++) begin
            req  = (c < len) || (c == extra);
            chan = ch;
            check_eq($sformatf("seq%0d_relay_off_c%0d", ch, c), int'(relay_off), int'(c >= 3 && c <= 6));
            check_eq($sformatf("seq%0d_relay_on_c%0d", ch, c),  int'(relay_on),  int'(c >= 9 && c <= 11));
            check_eq($sformatf("seq%0d_busy_c%0d", ch, c),      int'(busy),      int'(c >= 3 && c <= 12));
            check_eq($sformatf("seq%0d_done_c%0d", ch, c),      int'(done),      int'(c == 12));
            check_eq($sformatf("seq%0d_chan_out_c%0d", ch, c),  int'(chan_out),  int'((c >= 9) ? ch : prev));
            step();
        end
    endtask

    initial begin
        int n_done;

        rst  = 1'b1;
        req  = 1'b0;
        chan = 6'd0;
        step();
        step();
        check_eq("rst_relay_off", int'(relay_off), 0);
        check_eq("rst_relay_on",  int'(relay_on),  0);
        check_eq("rst_busy",      int'(busy),      0);
        check_eq("rst_done",      int'(done),      0);
        check_eq("rst_err",       int'(err),       0);
        check_eq("rst_chan_out",  int'(chan_out),  0);
        check_eq("rst_ovr_cnt",   int'(ovr_cnt),   0);
        rst = 1'b0;
        step();

        // Basic sequence, req high 5 clocks.
        run_accepted(6'd17, 6'd0, 5, -1);

        // Invalid channel: err pulse only.
        for (int c = 0; c < 8; c++) begin
            req  = (c < 2);
            chan = 6'd60;
            check_eq($sformatf("bad_err_c%0d", c),      int'(err),       int'(c == 3));
            check_eq($sformatf("bad_busy_c%0d", c),     int'(busy),      0);
            check_eq($sformatf("bad_relays_c%0d", c),   int'(relay_off | relay_on), 0);
            check_eq($sformatf("bad_chan_out_c%0d", c), int'(chan_out),  17);
            step();
        end

        // Second pulse during GAP is dropped and counted.
        run_accepted(6'd9, 6'd17, 2, 5);
        check_eq("gap_ovr_cnt", int'(ovr_cnt), 1);

        // Alternating pulses: 5 overruns per 12-cycle sequence, incl. DONE cycle.
        for (int c = 0; c < 50; c++) begin
            req  = ((c % 2) == 0) && (c < 49);
            chan = 6'd3;
            if (c == 12) check_eq("alt_done_c12", int'(done), 1);
            if (c == 13) begin
                check_eq("alt_ovr_c13",  int'(ovr_cnt), 6);
                check_eq("alt_busy_c13", int'(busy),    0);
            end
            step();
        end
        req = 1'b0;
        repeat (20) step();
        check_eq("sat_ovr_cnt", int'(ovr_cnt), 15);
        check_eq("sat_busy",    int'(busy),    0);
        check_eq("sat_chan_out", int'(chan_out), 3);

        // Reset during MAKE.
        for (int c = 0; c < 10; c++) begin
            req  = (c < 2);
            chan = 6'd22;
            step();
        end
        check_eq("mk_relay_on_pre", int'(relay_on), 1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mk_rst_relay_on", int'(relay_on), 0);
        check_eq("mk_rst_busy",     int'(busy),     0);
        check_eq("mk_rst_chan_out", int'(chan_out), 0);
        check_eq("mk_rst_ovr_cnt",  int'(ovr_cnt),  0);
        step();
        rst = 1'b0;
        n_done = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            n_done += int'(done);
            check_eq($sformatf("mk_post_relay_on_c%0d", c), int'(relay_on), 0);
        end
        check_eq("mk_post_done_cnt", n_done, 0);

        // Long request: exactly one sequence.
        req    = 1'b1;
        chan   = 6'd5;
        n_done = 0;
        for (int c = 0; c < 1000; c++) begin
            step();
            n_done += int'(done);
            if (relay_off && relay_on) check_eq("long_both_drives", 1, 0);
        end
        check_eq("long_done_cnt", n_done, 1);
        check_eq("long_ovr_cnt",  int'(ovr_cnt), 0);
        check_eq("long_chan_out", int'(chan_out), 5);

        // Request still high across a reset restarts once.
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            n_done += int'(done);
        end
        check_eq("rel_done_cnt", n_done, 1);
        check_eq("rel_chan_out", int'(chan_out), 5);
        check_eq("rel_ovr_cnt",  int'(ovr_cnt), 0);
        req = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cc_switch_seq.md
CC_SWITCH_SEQ -- requirements
Module: cc_switch_seq

Interface
REQ-001 Parameter T_BREAK, default 800000, number of clocks relay_off is held high (10 ms at 80 MHz).
REQ-002 Parameter T_GAP, default 400000, number of clocks with both relay drives low between break and make.
REQ-003 Parameter T_MAKE, default 800000, number of clocks relay_on is held high.
REQ-004 Parameter constraint: each of T_BREAK, T_GAP, T_MAKE SHALL be in the range 1..2^24-1, and the timer SHALL be 24 bits wide.
REQ-005 Port clk, input, 1, single system clock (80 MHz); all logic SHALL be synchronous to it.
REQ-006 Port rst, input, 1, reset, asynchronous and active-high.
REQ-007 Port req, input, 1, switch request from the 120 s commutation timer; it may arrive as a multi-cycle pulse.
REQ-008 Port chan, input, 6, target channel number, sampled on the accepted req edge.
REQ-009 Port relay_off, output, 1, break drive, registered.
REQ-010 Port relay_on, output, 1, make drive, registered.
REQ-011 Port chan_out, output, 6, currently connected channel, registered.
REQ-012 Port busy, output, 1, high while a switch sequence is in progress.
REQ-013 Port done, output, 1, one-clock pulse at sequence completion.
REQ-014 Port err, output, 1, one-clock pulse when the requested channel is invalid.
REQ-015 Port ovr_cnt, output, 4, saturating count of requests dropped while busy.

Function
REQ-016 req SHALL pass through a 3-stage shift register; an edge SHALL be recognized when stage1=1 and stage2=0, so one edge is recognized per req pulse regardless of its width.
REQ-017 States SHALL be IDLE, BREAK, GAP, MAKE and DONE.
REQ-018 IDLE, edge recognized, chan<60: the block SHALL latch chan, load the timer, enter BREAK and assert relay_off and busy on the same clock; relay_off SHALL rise 3 clocks after req is first sampled high.
REQ-019 IDLE, edge recognized, chan>=60: the block SHALL pulse err for exactly 1 clock, stay in IDLE, and leave chan_out unchanged.
REQ-020 BREAK SHALL last exactly T_BREAK clocks with relay_off=1, then transition to GAP.
REQ-021 GAP SHALL last exactly T_GAP clocks with relay_off=relay_on=0, then transition to MAKE.
REQ-022 On MAKE entry, chan_out SHALL take the latched channel; MAKE SHALL last exactly T_MAKE clocks with relay_on=1, then transition to DONE.
REQ-023 DONE SHALL last 1 clock with done=1, busy=1 and both relay drives low, then return to IDLE with busy=0.
REQ-024 relay_off and relay_on SHALL never be high in the same clock.
REQ-025 An edge recognized in any state other than IDLE SHALL be dropped and SHALL increment ovr_cnt, saturating at 15; the chan input is ignored in this case.
REQ-026 An edge recognized in the same cycle that DONE returns to IDLE SHALL be counted as an overrun, not accepted.
REQ-027 A request for the channel already in chan_out SHALL still run the full break/gap/make sequence.
REQ-028 Total busy time per accepted request SHALL be T_BREAK+T_GAP+T_MAKE+1 clocks.

Reset
REQ-029 On rst=1 the block SHALL immediately clear state to IDLE, the timer, the sync register, relay_off, relay_on, busy, done, err, ovr_cnt, and set chan_out to 0, independent of clk.
REQ-030 Reset asserted mid-sequence SHALL drop both relay drives within the reset assertion, with no done pulse.
REQ-031 After rst deasserts, a req already high SHALL produce an edge once and start a sequence only if chan<60.

Verification (bench parameters T_BREAK=4, T_GAP=2, T_MAKE=3)
REQ-032 req high 5 clocks, chan=17 -> relay_off high clocks 3-6, both drives low 7-8, relay_on high 9-11, chan_out=17 from clock 9, done at clock 12, busy high for 10 clocks.
REQ-033 req pulse with chan=60 -> err one clock, busy stays 0, chan_out unchanged, relay drives stay 0.
REQ-034 Second req pulse during GAP -> sequence completes unaltered, ovr_cnt=1; 20 overrun pulses -> ovr_cnt=15.
REQ-035 rst pulsed during MAKE -> relay_on=0, busy=0, chan_out=0, ovr_cnt=0 immediately, and no done pulse follows.
REQ-036 req held high for 1000 clocks, chan=5 -> exactly one sequence runs and ovr_cnt stays 0.
